// File: rtl/bsg_tq_pkg.sv
// ---------------------------------------------------------------------------
// bsg_tq_pkg
//
// Shared definitions for the task-queue receive-counter update scheduler.
//   - els_gp / width_gp : default receiver count and receive-counter width.
//   - lg_els_gp         : queue-id width for the defaults (never below 1).
//   - bsg_tq_update_s   : one outbound update packet {id, data} at the
//                         default widths.
//   - safe_clog2()      : clog2 that returns 1 for a single element, so a
//                         one-queue build still has a 1-bit id field.
// ---------------------------------------------------------------------------
package bsg_tq_pkg;

    localparam int els_gp   = 4;
    localparam int width_gp = 32;

    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int lg_els_gp = safe_clog2(els_gp);

    typedef struct packed {
        logic [lg_els_gp-1:0] id;
        logic [width_gp-1:0]  data;
    } bsg_tq_update_s;

endpackage

// File: rtl/bsg_tq_update_rr_arb.sv
// ---------------------------------------------------------------------------
// bsg_tq_update_rr_arb
//
// Round-robin arbiter over the per-queue update requests. The grant is the
// first requesting queue at or after rr_ptr, searching upward with wrap.
// rr_ptr moves to one past the granted queue only when the grant is used.
//
// Ports:
//   clk_i       in   clock
//   reset_i     in   asynchronous active-high reset (rr_ptr -> 0)
//   reqs_i      in   [els_p]    per-queue request
//   en_i        in   grant is consumed this cycle (advance the pointer)
//   grant_v_o   out  some queue is granted
//   grant_id_o  out  [lg_els_p] granted queue id (0 when nothing granted)
// ---------------------------------------------------------------------------
module bsg_tq_update_rr_arb
    import bsg_tq_pkg::*;
#(
    parameter int els_p    = els_gp,
    parameter int lg_els_p = safe_clog2(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [els_p-1:0]    reqs_i,
    input  logic                en_i,
    output logic                grant_v_o,
    output logic [lg_els_p-1:0] grant_id_o
);

    logic [lg_els_p-1:0] rr_ptr_q;
    logic [lg_els_p-1:0] rr_ptr_d;

    // Scan from the farthest candidate back to rr_ptr itself so the last hit
    // written is the closest one at or after the pointer; no early exit needed.
    always_comb begin
        int                  cand;
        logic [lg_els_p-1:0] idx;
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves one unassigned would infer a latch.
        grant_v_o  = 1'b0;
        grant_id_o = '0;
        cand       = 0;
        idx        = '0;
        for (int i = els_p - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= els_p) begin
                cand = cand - els_p;
            end
            idx = lg_els_p'(cand);
            if (reqs_i[idx]) begin
                grant_v_o  = 1'b1;
                grant_id_o = idx;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (en_i && grant_v_o) begin
            rr_ptr_d = (grant_id_o == lg_els_p'(els_p - 1)) ? '0 : grant_id_o + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/bsg_tq_update_sched.sv
// ---------------------------------------------------------------------------
// bsg_tq_update_sched
//
// Schedules receive-counter update packets from els_p task-queue receivers
// onto one shared outbound channel. Each queue holds at most one pending
// value; a newer value overwrites the older one (counters are monotonic, so
// only the latest matters). Pending queues are granted round-robin into a
// one-entry registered output slot with a valid/ready handshake.
//
// A request arriving on an idle queue may be granted in the same cycle
// (bypass), giving one cycle from in_v_i to out_v_o. When a queue that is
// already pending is granted while it also delivers a new value, the old
// value goes out and the new value stays pending.
//
// Ports:
//   clk_i        in   clock
//   reset_i      in   asynchronous active-high reset
//   in_v_i       in   [els_p]          per-queue update request
//   in_data_i    in   [els_p*width_p]  queue i at [i*width_p +: width_p]
//   in_yumi_o    out  [els_p]          accept; always equal to in_v_i
//   out_v_o      out  packet valid (registered)
//   out_id_o     out  [lg_els_p]       queue id of packet
//   out_data_o   out  [width_p]        counter value of packet
//   out_ready_i  in   channel takes packet when out_v_o & out_ready_i
//   pending_o    out  [els_p]          per-queue pending flag
//   error_o      out  sticky monotonicity error
//
// Optional feature (macro BSG_TQ_UPDATE_SCHED_MONOTONIC_CHECK_EN):
//   when defined, a new value that is "behind" the pending value of the same
//   queue (modular difference has its sign bit set) sets error_o until reset
//   and reports the queue id in simulation. When undefined, error_o is 0.
// ---------------------------------------------------------------------------
module bsg_tq_update_sched
    import bsg_tq_pkg::*;
#(
    parameter int els_p    = els_gp,
    parameter int width_p  = width_gp,
    parameter int lg_els_p = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [els_p-1:0]         in_v_i,
    input  logic [els_p*width_p-1:0] in_data_i,
    output logic [els_p-1:0]         in_yumi_o,
    output logic                     out_v_o,
    output logic [lg_els_p-1:0]      out_id_o,
    output logic [width_p-1:0]       out_data_o,
    input  logic                     out_ready_i,
    output logic [els_p-1:0]         pending_o,
    output logic                     error_o
);

    logic [width_p-1:0]  in_data [els_p];

    logic [els_p-1:0]    pending_q, pending_d;
    logic [width_p-1:0]  pend_data_q [els_p];

    logic                slot_v_q, slot_v_d;
    logic [lg_els_p-1:0] slot_id_q, slot_id_d;
    logic [width_p-1:0]  slot_data_q, slot_data_d;

    logic                slot_free;
    logic [els_p-1:0]    reqs;
    logic                grant_v;
    logic [lg_els_p-1:0] grant_id;
    logic [width_p-1:0]  grant_data;

    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            in_data[i] = in_data_i[i*width_p +: width_p];
        end
    end

    // Every request is absorbed immediately into the coalescing register.
    assign in_yumi_o = in_v_i;

    assign slot_free = ~slot_v_q | out_ready_i;

    // A fresh request on an idle queue competes in the same cycle.
    assign reqs = pending_q | in_v_i;

    bsg_tq_update_rr_arb #(
        .els_p    (els_p),
        .lg_els_p (lg_els_p)
    ) rr_arb (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .reqs_i     (reqs),
        .en_i       (slot_free),
        .grant_v_o  (grant_v),
        .grant_id_o (grant_id)
    );

    // An already-pending queue sends its stored (older) value; an idle queue
    // sends the value arriving this cycle.
    assign grant_data = pending_q[grant_id] ? pend_data_q[grant_id] : in_data[grant_id];

    always_comb begin
        pending_d   = pending_q | in_v_i;
        slot_v_d    = slot_v_q;
        slot_id_d   = slot_id_q;
        slot_data_d = slot_data_q;
        if (slot_free) begin
            slot_v_d = grant_v;
            if (grant_v) begin
                slot_id_d   = grant_id;
                slot_data_d = grant_data;
                // Stays pending only if an older value was sent while a newer
                // one arrived; a bypassed value leaves nothing behind.
                pending_d[grant_id] = pending_q[grant_id] & in_v_i[grant_id];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pending_q   <= '0;
            slot_v_q    <= 1'b0;
            slot_id_q   <= '0;
            slot_data_q <= '0;
        end else begin
            pending_q   <= pending_d;
            slot_v_q    <= slot_v_d;
            slot_id_q   <= slot_id_d;
            slot_data_q <= slot_data_d;
        end
    end

    // NOTE: the per-queue value registers are reset too: the array is only
    // els_p entries, and a defined value keeps debug views and the
    // monotonicity check free of X after reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                pend_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < els_p; i++) begin
                if (in_v_i[i]) begin
                    pend_data_q[i] <= in_data[i];
                end
            end
        end
    end

    assign out_v_o    = slot_v_q;
    assign out_id_o   = slot_id_q;
    assign out_data_o = slot_data_q;
    assign pending_o  = pending_q;

`ifdef BSG_TQ_UPDATE_SCHED_MONOTONIC_CHECK_EN
    logic [width_p-1:0] delta [els_p];
    logic [els_p-1:0]   backward;
    logic               error_q, error_d;

    // Modular difference: a set sign bit means the counter moved backward,
    // which stays correct across counter wrap-around.
    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            delta[i]    = in_data[i] - pend_data_q[i];
            backward[i] = in_v_i[i] & pending_q[i] & delta[i][width_p-1];
        end
    end

    assign error_d = error_q | (|backward);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < els_p; i++) begin
                if (backward[i]) begin
                    $error("bsg_tq_update_sched: receive counter moved backward on queue %0d", i);
                end
            end
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_tq_update_sched.sv
module tb_bsg_tq_update_sched;
    import bsg_tq_pkg::*;

    localparam int els_lp   = els_gp;
    localparam int width_lp = width_gp;
    localparam int lg_lp    = lg_els_gp;

    logic                        clk = 1'b0;
    logic                        reset_i;
    logic [els_lp-1:0]           in_v_i;
    logic [els_lp*width_lp-1:0]  in_data_i;
    logic [els_lp-1:0]           in_yumi_o;
    logic                        out_v_o;
    logic [lg_lp-1:0]            out_id_o;
    logic [width_lp-1:0]         out_data_o;
    logic                        out_ready_i;
    logic [els_lp-1:0]           pending_o;
    logic                        error_o;

    bsg_tq_update_sched #(
        .els_p   (els_lp),
        .width_p (width_lp)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .in_v_i      (in_v_i),
        .in_data_i   (in_data_i),
        .in_yumi_o   (in_yumi_o),
        .out_v_o     (out_v_o),
        .out_id_o    (out_id_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .pending_o   (pending_o),
        .error_o     (error_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic sb_en = 1'b0;
    bsg_tq_update_s exp_q[$];
    bsg_tq_update_s sb_e;
    logic err_exp;

    typedef struct {
        logic [3:0]   in_v;
        logic [127:0] data;
        logic         ready;
        logic         exp_v;
        logic [1:0]   exp_id;
        logic [31:0]  exp_data;
        logic [3:0]   exp_pend;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input int q, input logic [31:0] val);
        in_data_i[q*width_lp +: width_lp] = val;
    endtask

    task automatic push(input int id, input logic [31:0] val);
        bsg_tq_update_s e;
        e.id   = lg_lp'(id);
        e.data = val;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        in_v_i      = '0;
        in_data_i   = '0;
        out_ready_i = 1'b1;
        #2;
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    // Scoreboard: every handshake pops the oldest expected packet.
    always @(negedge clk) begin
        if (sb_en && !reset_i && out_v_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got id %0d data %0h expected no packet", out_id_o, out_data_o);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_id", 64'(out_id_o), 64'(sb_e.id));
                check("sb_data", 64'(out_data_o), 64'(sb_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef BSG_TQ_UPDATE_SCHED_MONOTONIC_CHECK_EN
        err_exp = 1'b1;
`else
        err_exp = 1'b0;
`endif
        // Round-robin sequence from reset: 1 (bypass), then 2,3,0,1 with wrap.
        vecs[0] = '{4'b0010, {32'h0, 32'h0, 32'h10, 32'h0}, 1'b1, 1'b1, 2'd1, 32'h10, 4'b0000};
        vecs[1] = '{4'b0000, 128'h0, 1'b1, 1'b0, 2'd0, 32'h0, 4'b0000};
        vecs[2] = '{4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1, 1'b1, 2'd2, 32'hA2, 4'b1011};
        vecs[3] = '{4'b0000, 128'h0, 1'b1, 1'b1, 2'd3, 32'hA3, 4'b0011};
        vecs[4] = '{4'b0000, 128'h0, 1'b1, 1'b1, 2'd0, 32'hA0, 4'b0010};
        vecs[5] = '{4'b0000, 128'h0, 1'b1, 1'b1, 2'd1, 32'hA1, 4'b0000};
        vecs[6] = '{4'b0000, 128'h0, 1'b1, 1'b0, 2'd0, 32'h0, 4'b0000};

        reset_i     = 1'b1;
        in_v_i      = '0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        #1;
        check("rst_out_v", 64'(out_v_o), 64'd0);
        check("rst_out_id", 64'(out_id_o), 64'd0);
        check("rst_out_data", 64'(out_data_o), 64'd0);
        check("rst_pending", 64'(pending_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        #11;
        reset_i = 1'b0;

        // Table-driven single update and round-robin order.
        for (int i = 0; i < 7; i++) begin
            in_v_i      = vecs[i].in_v;
            in_data_i   = vecs[i].data;
            out_ready_i = vecs[i].ready;
            step();
            check("vec_out_v", 64'(out_v_o), 64'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                check("vec_out_id", 64'(out_id_o), 64'(vecs[i].exp_id));
                check("vec_out_data", 64'(out_data_o), 64'(vecs[i].exp_data));
            end
            check("vec_pending", 64'(pending_o), 64'(vecs[i].exp_pend));
        end

        // Fairness: all four pending from rr_ptr=0 -> ids 0,1,2,3 back to back.
        do_reset();
        sb_en = 1'b1;
        in_v_i = 4'b1111;
        for (int q = 0; q < 4; q++) begin
            set_q(q, 32'hB0 + q);
            push(q, 32'hB0 + q);
        end
        step();
        in_v_i = '0;
        for (int i = 0; i < 4; i++) begin
            check("fair_v", 64'(out_v_o), 64'd1);
            check("fair_id", 64'(out_id_o), 64'(i));
            step();
        end
        check("fair_idle", 64'(out_v_o), 64'd0);

        // Fairness under ready toggling 1,0: each packet held stable once.
        in_v_i = 4'b1111;
        for (int q = 0; q < 4; q++) begin
            set_q(q, 32'hC0 + q);
            push(q, 32'hC0 + q);
        end
        step();
        in_v_i = '0;
        for (int i = 0; i < 4; i++) begin
            out_ready_i = 1'b0;
            step();
            check("hold_v", 64'(out_v_o), 64'd1);
            check("hold_id", 64'(out_id_o), 64'(i));
            check("hold_data", 64'(out_data_o), 64'(32'hC0 + i));
            out_ready_i = 1'b1;
            step();
        end
        check("hold_idle", 64'(out_v_o), 64'd0);

        // Coalescing: queue 2 sends 0x5 then 0x9 behind a blocked slot.
        out_ready_i = 1'b0;
        in_v_i = 4'b0010;
        set_q(1, 32'h77);
        push(1, 32'h77);
        step();
        check("coal_slot_id", 64'(out_id_o), 64'd1);
        in_v_i = 4'b0100;
        set_q(2, 32'h5);
        step();
        set_q(2, 32'h9);
        step();
        push(2, 32'h9);
        check("coal_pending", 64'(pending_o), 64'b0100);
        check("coal_slot_hold", 64'(out_data_o), 64'h77);
        in_v_i = '0;
        out_ready_i = 1'b1;
        step();
        check("coal_id", 64'(out_id_o), 64'd2);
        check("coal_data", 64'(out_data_o), 64'h9);
        check("coal_pend_clr", 64'(pending_o), 64'd0);
        step();
        check("coal_idle", 64'(out_v_o), 64'd0);

        // Same-cycle refresh: queue 0 granted (0x20) while sending 0x21.
        out_ready_i = 1'b0;
        in_v_i = 4'b0010;
        set_q(1, 32'h55);
        push(1, 32'h55);
        step();
        in_v_i = 4'b0001;
        set_q(0, 32'h20);
        step();
        check("refr_pending", 64'(pending_o), 64'b0001);
        push(0, 32'h20);
        push(0, 32'h21);
        out_ready_i = 1'b1;
        set_q(0, 32'h21);
        step();
        check("refr_id", 64'(out_id_o), 64'd0);
        check("refr_old", 64'(out_data_o), 64'h20);
        check("refr_still_pend", 64'(pending_o[0]), 64'd1);
        in_v_i = '0;
        step();
        check("refr_new", 64'(out_data_o), 64'h21);
        check("refr_pend_clr", 64'(pending_o), 64'd0);
        step();
        check("refr_idle", 64'(out_v_o), 64'd0);

        // Async reset mid-cycle with a loaded slot and pending 1011.
        out_ready_i = 1'b0;
        in_v_i = 4'b0010;
        set_q(1, 32'h31);
        step();
        in_v_i = 4'b1011;
        set_q(0, 32'h30);
        set_q(1, 32'h32);
        set_q(3, 32'h33);
        step();
        in_v_i = '0;
        check("ar_pre_v", 64'(out_v_o), 64'd1);
        check("ar_pre_pend", 64'(pending_o), 64'b1011);
        #2;
        reset_i = 1'b1;
        in_v_i  = 4'b0101;
        #1;
        check("ar_out_v", 64'(out_v_o), 64'd0);
        check("ar_pending", 64'(pending_o), 64'd0);
        check("ar_out_data", 64'(out_data_o), 64'd0);
        check("ar_yumi", 64'(in_yumi_o), 64'b0101);
        in_v_i = '0;
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        out_ready_i = 1'b1;
        in_v_i = 4'b0001;
        set_q(0, 32'h44);
        push(0, 32'h44);
        step();
        check("ar_post_v", 64'(out_v_o), 64'd1);
        check("ar_post_id", 64'(out_id_o), 64'd0);
        check("ar_post_data", 64'(out_data_o), 64'h44);
        in_v_i = '0;
        step();
        check("ar_post_idle", 64'(out_v_o), 64'd0);

        // Monotonicity: queue 3 pending 0x100 then receives 0x0FF.
        out_ready_i = 1'b0;
        in_v_i = 4'b0010;
        set_q(1, 32'h66);
        push(1, 32'h66);
        step();
        in_v_i = 4'b1000;
        set_q(3, 32'h100);
        step();
        check("mono_pre_err", 64'(error_o), 64'd0);
        set_q(3, 32'h0FF);
        step();
        push(3, 32'h0FF);
        check("mono_err", 64'(error_o), 64'(err_exp));
        in_v_i = '0;
        out_ready_i = 1'b1;
        step();
        step();
        step();
        check("mono_sticky", 64'(error_o), 64'(err_exp));

        // Bounded drain of the scoreboard.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
            step();
        end
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
